// File: rtl/excite_scheduler_pkg.sv
// rtl/excite_scheduler_pkg.sv - shared state encoding and default sizes for the excitation scheduler
package excite_scheduler_pkg;

   localparam int CH_NUM_DEF = 8;
   localparam int CNT_W_DEF  = 16;
   localparam int PHASE_W    = 12;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_FIRE   = 3'd2,
      S_LISTEN = 3'd3,
      S_NEXT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/excite_scheduler_seq_timer.sv
// rtl/excite_scheduler_seq_timer.sv - loadable down-counter timing the FIRE and LISTEN windows
module seq_timer #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Load wins over decrement so a window can be re-armed in its own final cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/excite_scheduler.sv
// rtl/excite_scheduler.sv - per-channel transducer burst/listen frame sequencer driving a DDS
module excite_scheduler
   import excite_scheduler_pkg::*;
#(
   parameter int CH_NUM = CH_NUM_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   localparam int SEL_W = $clog2(CH_NUM)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [31:0]        i_cfg_fword,
   input  logic [PHASE_W-1:0] i_cfg_pstep,
   input  logic [CNT_W-1:0]   i_cfg_burst,
   input  logic [CNT_W-1:0]   i_cfg_listen,
   input  logic [CH_NUM-1:0]  i_cfg_chmask,
   output logic               o_dds_en,
   output logic [31:0]        o_dds_fword,
   output logic [PHASE_W-1:0] o_dds_pword,
   output logic [SEL_W-1:0]   o_ch_sel,
   output logic               o_rx_gate,
   output logic               o_busy,
   output logic               o_done
);

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_fword;
   logic [PHASE_W-1:0] r_pstep;
   logic [CNT_W-1:0]   r_burst;
   logic [CNT_W-1:0]   r_listen;
   logic [CH_NUM-1:0]  r_mask;
   logic [SEL_W-1:0]   r_ch_sel;
   logic [PHASE_W-1:0] r_phase;
   logic               w_tc;
   logic               w_tmr_load;
   logic [CNT_W-1:0]   w_tmr_val;
   logic               w_tmr_dec;
   logic               w_frame_start;

   assign w_frame_start = (r_state == S_IDLE) && (w_next == S_LOAD);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start && !i_abort) w_next = S_LOAD;
         S_LOAD: begin
            if (!r_mask[r_ch_sel])     w_next = S_NEXT;
            else if (r_burst != '0)    w_next = S_FIRE;
            else if (r_listen != '0)   w_next = S_LISTEN;
            else                       w_next = S_NEXT;
         end
         S_FIRE:   if (w_tc) w_next = (r_listen != '0) ? S_LISTEN : S_NEXT;
         S_LISTEN: if (w_tc) w_next = S_NEXT;
         S_NEXT:   w_next = (r_ch_sel == SEL_W'(CH_NUM - 1)) ? S_DONE : S_LOAD;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
   end

   // Arm the timer on entry to either timed window.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = r_listen;
      if ((w_next == S_FIRE) && (r_state != S_FIRE)) begin
         w_tmr_load = 1'b1;
         w_tmr_val  = r_burst;
      end else if ((w_next == S_LISTEN) && (r_state != S_LISTEN)) begin
         w_tmr_load = 1'b1;
      end
   end

   assign w_tmr_dec = (r_state == S_FIRE) || (r_state == S_LISTEN);

   seq_timer #(.CNT_W(CNT_W)) u_seq_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_tc       (w_tc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_fword     <= '0;
         r_pstep     <= '0;
         r_burst     <= '0;
         r_listen    <= '0;
         r_mask      <= '0;
         r_ch_sel    <= '0;
         r_phase     <= '0;
         o_dds_en    <= 1'b0;
         o_rx_gate   <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_dds_fword <= '0;
      end else begin
         r_state <= w_next;
         if (w_frame_start) begin
            r_fword  <= i_cfg_fword;
            r_pstep  <= i_cfg_pstep;
            r_burst  <= i_cfg_burst;
            r_listen <= i_cfg_listen;
            r_mask   <= i_cfg_chmask;
            r_ch_sel <= '0;
            r_phase  <= '0;
         end else if ((r_state == S_NEXT) && (w_next == S_LOAD)) begin
            r_ch_sel <= r_ch_sel + 1'b1;
            r_phase  <= r_phase + r_pstep;
         end else if (w_next == S_IDLE) begin
            r_ch_sel <= '0;
            r_phase  <= '0;
         end
         // Outputs are decoded from the next state so they line up with the state they describe.
         o_dds_en    <= (w_next == S_FIRE);
         o_rx_gate   <= (w_next == S_LISTEN);
         o_busy      <= (w_next != S_IDLE);
         o_done      <= (w_next == S_DONE);
         o_dds_fword <= (w_next == S_IDLE) ? '0 : (w_frame_start ? i_cfg_fword : r_fword);
      end
   end

   assign o_ch_sel    = r_ch_sel;
   assign o_dds_pword = r_phase;

endmodule

// File: tb/tb_excite_scheduler.sv
// tb/tb_excite_scheduler.sv - randomized self-checking bench for excite_scheduler against a frame-level model
module tb_excite_scheduler;

   localparam int CH_NUM = 8;
   localparam int CNT_W  = 16;
   localparam int SEL_W  = 3;
   localparam int VEC_W  = 4 + SEL_W + 12 + 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [31:0]        cfg_fword = '0;
   logic [11:0]        cfg_pstep = '0;
   logic [CNT_W-1:0]   cfg_burst = '0;
   logic [CNT_W-1:0]   cfg_listen = '0;
   logic [CH_NUM-1:0]  cfg_mask = '0;
   logic               dds_en;
   logic [31:0]        dds_fword;
   logic [11:0]        dds_pword;
   logic [SEL_W-1:0]   ch_sel;
   logic               rx_gate;
   logic               busy;
   logic               done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   excite_scheduler #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_abort      (abort),
      .i_cfg_fword  (cfg_fword),
      .i_cfg_pstep  (cfg_pstep),
      .i_cfg_burst  (cfg_burst),
      .i_cfg_listen (cfg_listen),
      .i_cfg_chmask (cfg_mask),
      .o_dds_en     (dds_en),
      .o_dds_fword  (dds_fword),
      .o_dds_pword  (dds_pword),
      .o_ch_sel     (ch_sel),
      .o_rx_gate    (rx_gate),
      .o_busy       (busy),
      .o_done       (done)
   );

   // {done, busy, dds_en, rx_gate, ch_sel, pword, fword}
   function automatic logic [VEC_W-1:0] mk(input bit d, input bit b, input bit e, input bit r,
                                           input int ch, input logic [11:0] pw, input logic [31:0] fw);
      logic [SEL_W-1:0] c;
      c = ch[SEL_W-1:0];
      return {d, b, e, r, c, pw, fw};
   endfunction

   function automatic logic [VEC_W-1:0] observed();
      return {done, busy, dds_en, rx_gate, ch_sel, dds_pword, dds_fword};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Runs one frame from IDLE and checks every busy cycle plus the first idle cycle after it.
   task automatic run_frame(input logic [31:0] fw, input logic [11:0] ps, input int bu, input int li,
                            input logic [CH_NUM-1:0] mask, input int poke_at,
                            output int busy_cnt, output int done_cnt);
      logic [VEC_W-1:0] exp_q[$];
      logic [VEC_W-1:0] obs;
      logic [11:0]      pw;
      int               nprint;
      exp_q.delete();
      for (int ch = 0; ch < CH_NUM; ch++) begin
         pw = 12'((ch * int'(ps)) % 4096);
         exp_q.push_back(mk(0, 1, 0, 0, ch, pw, fw));
         if (mask[ch]) begin
            for (int k = 0; k < bu; k++) exp_q.push_back(mk(0, 1, 1, 0, ch, pw, fw));
            for (int k = 0; k < li; k++) exp_q.push_back(mk(0, 1, 0, 1, ch, pw, fw));
         end
         exp_q.push_back(mk(0, 1, 0, 0, ch, pw, fw));
      end
      exp_q.push_back(mk(1, 1, 0, 0, CH_NUM - 1, 12'((CH_NUM - 1) * int'(ps) % 4096), fw));
      cfg_fword = fw; cfg_pstep = ps; cfg_burst = CNT_W'(bu); cfg_listen = CNT_W'(li); cfg_mask = mask;
      start = 1'b1;
      step(1);
      start = 1'b0;
      busy_cnt = 0; done_cnt = 0; nprint = 0;
      foreach (exp_q[i]) begin
         obs = observed();
         busy_cnt += int'(busy);
         done_cnt += int'(done);
         n_tests++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            if (nprint < 8) $display("FAIL frame_cycle %0d: got %h expected %h", i, obs, exp_q[i]);
            nprint++;
         end
         if (dds_en && rx_gate) begin
            n_fail++;
            $display("FAIL en_rx_overlap cycle %0d: dds_en=1 rx_gate=1 expected not both", i);
         end
         if (i == poke_at) begin
            start = 1'b1; cfg_fword = ~fw; cfg_pstep = ~ps; cfg_burst = '1; cfg_mask = ~mask;
         end else begin
            start = 1'b0;
         end
         step(1);
      end
      start = 1'b0;
      n_tests++;
      if ({busy, done, dds_en, rx_gate, dds_fword} !== 36'h0) begin
         n_fail++;
         $display("FAIL frame_end_idle: busy=%b done=%b en=%b rx=%b fword=%h expected all 0",
                  busy, done, dds_en, rx_gate, dds_fword);
      end
   endtask

   task automatic test_reset();
      step(3);
      n_tests++;
      if ({busy, done, dds_en, rx_gate, ch_sel, dds_pword, dds_fword} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected 0", observed());
      end
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_nominal();
      int bc, dc;
      run_frame(32'h1234_5678, 12'h300, 10, 20, 8'hFF, -1, bc, dc);
      n_tests++;
      if (bc !== 257) begin n_fail++; $display("FAIL nominal_busy_cycles: got %0d expected 257", bc); end
      n_tests++;
      if (dc !== 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d expected 1", dc); end
   endtask

   task automatic test_mask();
      int bc, dc;
      run_frame(32'hCAFE_0001, 12'h155, 4, 3, 8'h05, -1, bc, dc);
      n_tests++;
      if (bc !== 2 * (1 + 4 + 3 + 1) + 6 * 2 + 1) begin
         n_fail++; $display("FAIL mask05_busy_cycles: got %0d expected %0d", bc, 2 * 9 + 13);
      end
   endtask

   task automatic test_zero_lengths();
      int bc, dc;
      run_frame(32'h0BAD_F00D, 12'h7FF, 0, 0, 8'hFF, -1, bc, dc);
      n_tests++;
      if (bc !== 17) begin n_fail++; $display("FAIL zero_len_busy_cycles: got %0d expected 17", bc); end
      run_frame(32'h0000_0042, 12'h001, 5, 5, 8'h00, -1, bc, dc);
      n_tests++;
      if (dc !== 1) begin n_fail++; $display("FAIL zero_mask_done: got %0d expected 1", dc); end
      run_frame(32'h0000_0099, 12'hA00, 0, 3, 8'h81, -1, bc, dc);
   endtask

   task automatic test_abort();
      int dc, bc;
      cfg_fword = 32'hA5A5_0003; cfg_pstep = 12'h010; cfg_burst = 10; cfg_listen = 20; cfg_mask = 8'hFF;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(100);
      n_tests++;
      if (!(dds_en === 1'b1 && ch_sel === 3'd3)) begin
         n_fail++; $display("FAIL abort_setup: dds_en=%b ch_sel=%0d expected 1 and 3", dds_en, ch_sel);
      end
      abort = 1'b1;
      step(1);
      n_tests++;
      if ({dds_en, rx_gate, busy, done} !== 4'b0) begin
         n_fail++; $display("FAIL abort_next_cycle: en/rx/busy/done=%b expected 0000", {dds_en, rx_gate, busy, done});
      end
      abort = 1'b0;
      dc = 0;
      for (int i = 0; i < 40; i++) begin dc += int'(done) + int'(busy); step(1); end
      n_tests++;
      if (dc !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", dc); end
      run_frame(32'h1111_2222, 12'h123, 3, 2, 8'hFF, -1, bc, dc);
      n_tests++;
      if (dc !== 1) begin n_fail++; $display("FAIL abort_recover_done: got %0d expected 1", dc); end
   endtask

   task automatic test_start_ignored();
      int bc, dc;
      run_frame(32'h7777_8888, 12'h0F0, 6, 5, 8'hFF, 30, bc, dc);
      n_tests++;
      if (bc !== 8 * 13 + 1) begin n_fail++; $display("FAIL restart_busy_cycles: got %0d expected %0d", bc, 8 * 13 + 1); end
      start = 1'b1; abort = 1'b1; cfg_fword = 32'hDEAD_BEEF;
      step(1);
      start = 1'b0;
      step(1);
      abort = 1'b0;
      n_tests++;
      if ({busy, dds_fword} !== 33'h0) begin
         n_fail++; $display("FAIL start_abort_idle: busy=%b fword=%h expected 0", busy, dds_fword);
      end
   endtask

   task automatic test_reset_midframe();
      int bc, dc;
      cfg_fword = 32'h5555_AAAA; cfg_pstep = 12'h321; cfg_burst = 8; cfg_listen = 8; cfg_mask = 8'hFF;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(37);
      rst_n = 1'b0;
      #2;
      n_tests++;
      if ({busy, done, dds_en, rx_gate, ch_sel, dds_pword, dds_fword} !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h expected 0", observed());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 30; i++) begin dc += int'(done) + int'(busy); step(1); end
      n_tests++;
      if (dc !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d expected 0", dc); end
      run_frame(32'h0F0F_F0F0, 12'hFFF, 2, 1, 8'h5A, -1, bc, dc);
   endtask

   task automatic test_random();
      int bc, dc, bu, li;
      logic [CH_NUM-1:0] m;
      for (int t = 0; t < 8; t++) begin
         bu = int'($urandom_range(0, 6));
         li = int'($urandom_range(0, 6));
         m  = CH_NUM'($urandom);
         run_frame($urandom, 12'($urandom), bu, li, m, int'($urandom_range(0, 10)), bc, dc);
         n_tests++;
         if (dc !== 1) begin n_fail++; $display("FAIL random_done %0d: got %0d expected 1", t, dc); end
         step(int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_nominal();
      test_mask();
      test_zero_lengths();
      test_abort();
      test_start_ignored();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
